ppu_timing: RTL

Dot and scanline timing generator for the NES PPU. Runs on the master clock and advances one PPU dot per `ppu_ce` pulse from the clock generator. Tracks dot and scanline position across a 341 x 262 NTSC frame, including the odd-frame dot skip. Owns the VBlank status flag and drives the active-low NMI line to the CPU; the rendering pipeline and the CPU-side register interface consume its outputs.

---
 rtl/nes_pkg.sv | 18 +
 rtl/ppu_vblank_ctrl.sv | 46 ++++
 rtl/ppu_timing.sv | 102 ++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// nes_pkg: shared NES PPU timing constants and types.
//   NTSC frame geometry, the visible window and the 9-bit position type
//   used by the dot/scanline counters.
package nes_pkg;

  typedef logic [8:0] ppu_pos_t;

  localparam int DOTS_PER_LINE   = 341;  // dots 0..340
  localparam int LINES_PER_FRAME = 262;  // scanlines 0..261
  localparam int VBLANK_LINE     = 241;
  localparam int PRERENDER_LINE  = 261;

  // Visible window: scanlines 0..VIS_LINES-1, dots VIS_DOT_FIRST..VIS_DOT_LAST
  localparam int VIS_LINES     = 240;
  localparam int VIS_DOT_FIRST = 1;
  localparam int VIS_DOT_LAST  = 256;

endpackage

// File: rtl/ppu_vblank_ctrl.sv
// ppu_vblank_ctrl: PPUSTATUS VBlank flag and CPU NMI generation.
//   m_clk, reset    : master clock, synchronous active-high reset
//   set_evt/clr_evt : one-cycle strobes from the counters at (vblank,1)/(prerender,1)
//   status_rd       : CPU $2002 read strobe, clears the flag
//   nmi_en          : PPUCTRL bit 7
//   vblank_flag     : registered flag
//   nmi_n           : registered active-low NMI
module ppu_vblank_ctrl (
  input  logic m_clk,
  input  logic reset,
  input  logic set_evt,
  input  logic clr_evt,
  input  logic status_rd,
  input  logic nmi_en,
  output logic vblank_flag,
  output logic nmi_n
);

  logic flag_d, flag_q;
  logic nmi_n_d, nmi_n_q;

  always_comb begin
    flag_d = flag_q;
    // A read landing on the set edge wins: the flag never rises this frame,
    // since the set event only occurs once per frame.
    if (status_rd)    flag_d = 1'b0;
    else if (set_evt) flag_d = 1'b1;
    else if (clr_evt) flag_d = 1'b0;
    // Level-based, so re-enabling nmi_en with the flag up re-asserts NMI.
    nmi_n_d = ~(flag_q & nmi_en);
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      flag_q  <= 1'b0;
      nmi_n_q <= 1'b1;
    end else begin
      flag_q  <= flag_d;
      nmi_n_q <= nmi_n_d;
    end
  end

  assign vblank_flag = flag_q;
  assign nmi_n       = nmi_n_q;

endmodule

// File: rtl/ppu_timing.sv
// ppu_timing: NES PPU dot/scanline timing generator.
//   m_clk, reset : master clock, synchronous active-high reset
//   ppu_ce       : dot enable, one m_clk cycle per PPU dot
//   render_en    : rendering enabled (sampled at the odd-frame skip point only)
//   nmi_en       : NMI on VBlank enable
//   status_rd    : CPU $2002 read strobe
//   dot/scanline : registered position; frame_odd: frame parity
//   visible      : position inside the visible window (combinational)
//   vblank_flag  : PPUSTATUS bit 7; nmi_n: NMI to CPU, active low
// Geometry parameters default to the NTSC frame from nes_pkg.
module ppu_timing
  import nes_pkg::*;
#(
  parameter int DOTS_PER_LINE   = nes_pkg::DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = nes_pkg::LINES_PER_FRAME,
  parameter int VBLANK_LINE     = nes_pkg::VBLANK_LINE,
  parameter int PRERENDER_LINE  = nes_pkg::PRERENDER_LINE,
  parameter int VIS_LINES       = nes_pkg::VIS_LINES,
  parameter int VIS_DOT_FIRST   = nes_pkg::VIS_DOT_FIRST,
  parameter int VIS_DOT_LAST    = nes_pkg::VIS_DOT_LAST
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic       ppu_ce,
  input  logic       render_en,
  input  logic       nmi_en,
  input  logic       status_rd,
  output logic [8:0] dot,
  output logic [8:0] scanline,
  output logic       frame_odd,
  output logic       visible,
  output logic       vblank_flag,
  output logic       nmi_n
);

  localparam ppu_pos_t LAST_DOT  = ppu_pos_t'(DOTS_PER_LINE - 1);
  localparam ppu_pos_t SKIP_DOT  = ppu_pos_t'(DOTS_PER_LINE - 2);
  localparam ppu_pos_t LAST_LINE = ppu_pos_t'(LINES_PER_FRAME - 1);
  localparam ppu_pos_t VBL_LINE  = ppu_pos_t'(VBLANK_LINE);
  localparam ppu_pos_t PRE_LINE  = ppu_pos_t'(PRERENDER_LINE);
  localparam ppu_pos_t EVT_DOT   = ppu_pos_t'(1);
  localparam ppu_pos_t VIS_L_END = ppu_pos_t'(VIS_LINES);
  localparam ppu_pos_t VIS_D_LO  = ppu_pos_t'(VIS_DOT_FIRST);
  localparam ppu_pos_t VIS_D_HI  = ppu_pos_t'(VIS_DOT_LAST);

  ppu_pos_t dot_d, dot_q;
  ppu_pos_t line_d, line_q;
  logic     odd_d, odd_q;
  logic     skip, set_evt, clr_evt;

  always_comb begin
    dot_d  = dot_q;
    line_d = line_q;
    odd_d  = odd_q;
    // Odd frames with rendering on drop the last dot of the pre-render line.
    skip    = odd_q && render_en && (line_q == PRE_LINE) && (dot_q == SKIP_DOT);
    set_evt = ppu_ce && (line_q == VBL_LINE) && (dot_q == EVT_DOT);
    clr_evt = ppu_ce && (line_q == PRE_LINE) && (dot_q == EVT_DOT);
    if (ppu_ce) begin
      if (skip || (dot_q == LAST_DOT)) begin
        dot_d = '0;
        if (skip || (line_q == LAST_LINE)) begin
          line_d = '0;
          odd_d  = ~odd_q;
        end else begin
          line_d = line_q + 9'd1;
        end
      end else begin
        dot_d = dot_q + 9'd1;
      end
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      dot_q  <= '0;
      line_q <= '0;
      odd_q  <= 1'b0;
    end else begin
      dot_q  <= dot_d;
      line_q <= line_d;
      odd_q  <= odd_d;
    end
  end

  ppu_vblank_ctrl u_vblank (
    .m_clk       (m_clk),
    .reset       (reset),
    .set_evt     (set_evt),
    .clr_evt     (clr_evt),
    .status_rd   (status_rd),
    .nmi_en      (nmi_en),
    .vblank_flag (vblank_flag),
    .nmi_n       (nmi_n)
  );

  assign dot       = dot_q;
  assign scanline  = line_q;
  assign frame_odd = odd_q;
  assign visible   = (line_q < VIS_L_END) && (dot_q >= VIS_D_LO) && (dot_q <= VIS_D_HI);

endmodule
